// File: rtl/joint_stepper_pkg.sv
// Shared constants and types for the N-coil stepper joint driver.
package joint_stepper_pkg;
  localparam logic [1:0] STEPMODE_WAVE = 2'd0;
  localparam logic [1:0] STEPMODE_FULL = 2'd1;
  localparam logic [1:0] STEPMODE_HALF = 2'd2;
  localparam int         PWM_W         = 8;

  typedef enum logic {
    TGL_LOW  = 1'b0,
    TGL_HIGH = 1'b1
  } tgl_state_e;
endpackage

// File: rtl/joint_stepper_nphase_if.sv
// Joint command/feedback and coil bus between the joint registers and the stepper driver.
interface joint_stepper_nphase_if #(
  parameter int COILS = 4
);
  logic               jointEnable;
  logic signed [31:0] jointFreqCmd;
  logic [1:0]         stepMode;
  logic signed [31:0] jointFeedback;
  logic [COILS-1:0]   coils;

  modport master (
    output jointEnable, jointFreqCmd, stepMode,
    input  jointFeedback, coils
  );

  modport slave (
    input  jointEnable, jointFreqCmd, stepMode,
    output jointFeedback, coils
  );
endinterface

// File: rtl/joint_stepper_nphase_decode.sv
// Combinational half-step position to coil pattern decode: even p -> coil p/2,
// odd p -> coils (p-1)/2 and (p+1)/2 mod N.
module stepper_phase_decode #(
  parameter  int COILS = 4,
  localparam int POS_W = $clog2(2 * COILS)
) (
  input  logic [POS_W-1:0] pos,
  output logic [COILS-1:0] pattern
);
  logic [POS_W-1:0] lo;
  logic [POS_W-1:0] hi;

  always_comb begin
    lo      = pos >> 1;
    hi      = (lo == POS_W'(COILS - 1)) ? '0 : lo + POS_W'(1);
    pattern = '0;
    for (int k = 0; k < COILS; k++) begin
      pattern[k] = (lo == POS_W'(k)) || (pos[0] && (hi == POS_W'(k)));
    end
  end
endmodule

// File: rtl/joint_stepper_nphase.sv
// N-coil stepper joint driver: step-period command to coil pattern, signed step
// feedback, wave/full/half excitation and PWM hold-current reduction when idle.
module joint_stepper_nphase
  import joint_stepper_pkg::*;
#(
  parameter int COILS      = 4,
  parameter int HOLD_DELAY = 50000,
  parameter int HOLD_DUTY  = 64
) (
  input logic                   clk,
  input logic                   reset,
  joint_stepper_nphase_if.slave bus
);
  localparam int POS_W  = $clog2(2 * COILS);
  localparam int IDLE_W = (HOLD_DELAY < 1) ? 1 : $clog2(HOLD_DELAY + 1);
  localparam logic [IDLE_W-1:0] IDLE_SAT = IDLE_W'(HOLD_DELAY);

  logic [31:0]        cmd_abs_p0;
  logic [31:0]        cnt;
  tgl_state_e         state, state_nxt;
  logic [POS_W-1:0]   pos, pos_nxt;
  logic signed [31:0] fb;
  logic [IDLE_W-1:0]  idle, idle_nxt;
  logic [PWM_W-1:0]   pwm;
  logic [COILS-1:0]   coils_r, coils_nxt, pattern;
  logic               period_hit, step, fwd, misalign, hold, gate;

  // -2^31 has no positive counterpart in 32 bits, so clamp it.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v);
    if (v == 32'sh8000_0000) return 32'h7fff_ffff;
    return v[31] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [POS_W-1:0] pos_add(input logic [POS_W-1:0] p, input int d);
    int s;
    s = (int'(p) + d) % (2 * COILS);
    return POS_W'(s);
  endfunction

  // Toggle FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= TGL_LOW;
    else       state <= state_nxt;
  end

  // Toggle FSM: next state
  always_comb begin
    state_nxt = state;
    if (!bus.jointEnable)  state_nxt = TGL_LOW;
    else if (period_hit)   state_nxt = (state == TGL_LOW) ? TGL_HIGH : TGL_LOW;
  end

  // Toggle FSM: outputs
  always_comb begin
    period_hit = bus.jointEnable && (cmd_abs_p0 != 32'd0) && (cnt >= cmd_abs_p0);
    step       = period_hit && (state == TGL_HIGH);
  end

  always_comb begin
    fwd      = !bus.jointFreqCmd[31];
    misalign = ((bus.stepMode == STEPMODE_WAVE) && pos[0]) ||
               ((bus.stepMode == STEPMODE_FULL) && !pos[0]);
    pos_nxt  = pos;
    if (step) begin
      if (bus.stepMode[1]) pos_nxt = pos_add(pos, fwd ? 1 : 2 * COILS - 1);
      else                 pos_nxt = pos_add(pos, fwd ? 2 : 2 * COILS - 2);
    end else if (bus.jointEnable && misalign) begin
      pos_nxt = pos_add(pos, 1);
    end

    idle_nxt = idle;
    if (!bus.jointEnable || step) idle_nxt = '0;
    else if (idle != IDLE_SAT)    idle_nxt = idle + IDLE_W'(1);

    // idle_nxt is zero on a step, so the new pattern goes out at full drive
    hold      = (idle_nxt >= IDLE_SAT);
    gate      = !hold || (int'(pwm) < HOLD_DUTY);
    coils_nxt = bus.jointEnable ? (pattern & {COILS{gate}}) : '0;
  end

  stepper_phase_decode #(.COILS(COILS)) u_decode (
    .pos     (pos_nxt),
    .pattern (pattern)
  );

  // Stage p0: command magnitude; counters, position and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_abs_p0 <= '0;
      cnt        <= '0;
      pos        <= '0;
      fb         <= '0;
      idle       <= '0;
      pwm        <= '0;
      coils_r    <= '0;
    end else begin
      cmd_abs_p0 <= sat_abs(bus.jointFreqCmd);
      if (!bus.jointEnable || period_hit) cnt <= '0;
      else                                cnt <= cnt + 32'd1;
      pos     <= pos_nxt;
      if (step) fb <= fwd ? fb + 32'sd1 : fb - 32'sd1;
      idle    <= idle_nxt;
      pwm     <= pwm + PWM_W'(1);
      coils_r <= coils_nxt;
    end
  end

  assign bus.jointFeedback = fb;
  assign bus.coils         = coils_r;
endmodule
